// File: rtl/booth_pkg.sv
// Shared constants and the Booth digit-control type for the brightness multiplier.
package booth_pkg;

  localparam int DFLT_MCAND_W = 16;
  localparam int DFLT_MPLR_W  = 8;

  // Partial-product width seen by the downstream half_adder; the extra two bits
  // cover the x2 shift and the sign of the most negative multiplicand.
  localparam int PP_W = DFLT_MCAND_W + 2;
  localparam int NDIG = DFLT_MPLR_W / 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic neg;   // digit is negative
    logic two;   // magnitude is 2
    logic zero;  // digit is zero
  } booth_ctrl_t;

endpackage

// File: rtl/booth_digit_encoder.sv
// Radix-4 Booth digit encoder: triplet (b2i+1, b2i, b2i-1) -> {neg, two, zero}.
module booth_digit_encoder
  import booth_pkg::*;
(
  input  logic [2:0]  triplet_i,
  output booth_ctrl_t ctrl_o
);

  // Decode the triplet into sign, magnitude-2 and zero flags.
  always_comb begin
    ctrl_o      = '0;
    ctrl_o.zero = (triplet_i == 3'b000) || (triplet_i == 3'b111);
    ctrl_o.two  = (triplet_i == 3'b011) || (triplet_i == 3'b100);
    ctrl_o.neg  = triplet_i[2] && (triplet_i != 3'b111);
  end

endmodule

// File: rtl/booth_pp_generator.sv
// Sequential radix-4 Booth partial-product generator: one digit per cycle,
// products emitted in one's-complement form with a separate +1 sign_bit.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no operation in flight, ready for an operand pair
// RUN     | emitting digit idx of the current operation (out_valid high)
module booth_pp_generator
  import booth_pkg::*;
#(
  parameter  int MCAND_W  = DFLT_MCAND_W,
  parameter  int MPLR_W   = DFLT_MPLR_W,
  localparam int PP_WIDTH = MCAND_W + 2,
  localparam int N_DIG    = MPLR_W / 2,
  localparam int IDX_W    = $clog2(N_DIG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MCAND_W-1:0]  in_mcand,
  input  logic [MPLR_W-1:0]   in_mplr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PP_WIDTH-1:0] pp,
  output logic                sign_bit,
  output logic [IDX_W-1:0]    pp_idx,
  output logic                pp_last
);

  logic [0:0]          state_q, state_d;
  logic [MCAND_W-1:0]  m_q, m_d;
  logic [MPLR_W:0]     q_q, q_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  booth_ctrl_t         ctrl;
  logic                running;
  logic                last_digit;
  logic                accept;
  logic                xfer;
  logic [PP_WIDTH-1:0] mx;
  logic [PP_WIDTH-1:0] mag;

  assign running    = (state_q == ST_RUN);
  assign last_digit = (idx_q == IDX_W'(N_DIG - 1));

  // A new pair may enter while the final digit of the previous one drains,
  // which gives back-to-back operations without a bubble.
  assign out_valid = running;
  assign pp_last   = running && last_digit;
  assign in_ready  = !running || (pp_last && out_ready);
  assign pp_idx    = idx_q;

  assign accept = in_valid && in_ready;
  assign xfer   = running && out_ready;

  booth_digit_encoder u_enc (
    .triplet_i (q_q[2:0]),
    .ctrl_o    (ctrl)
  );

  // Select/shift/invert the multiplicand; outputs stay zero outside RUN.
  always_comb begin
    mx       = {{2{m_q[MCAND_W-1]}}, m_q};
    mag      = ctrl.two ? (mx << 1) : mx;
    pp       = '0;
    sign_bit = 1'b0;
    if (running && !ctrl.zero) begin
      pp       = ctrl.neg ? ~mag : mag;
      sign_bit = ctrl.neg;
    end
  end

  // Next-state: advance on a digit transfer, reload on acceptance (acceptance wins).
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    idx_d   = idx_q;
    if (xfer) begin
      q_d   = $signed(q_q) >>> 2;
      idx_d = idx_q + IDX_W'(1);
      if (last_digit) begin
        state_d = ST_IDLE;
      end
    end
    if (accept) begin
      state_d = ST_RUN;
      m_d     = in_mcand;
      q_d     = {in_mplr, 1'b0};
      idx_d   = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      idx_q   <= idx_d;
    end
  end

endmodule
